// File: rtl/wb_burst_reader_if.sv
// Wishbone classic/burst master bus plus the read-data word stream of wb_burst_reader.
// The master modport is the reader's view; the slave modport is the bus/sink side.
interface wb_burst_reader_if;
   logic [31:0] wbm_adr_o;
   logic [3:0]  wbm_sel_o;
   logic [2:0]  wbm_cti_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic [31:0] st_data_o;
   logic        st_valid_o;
   logic        st_ready_i;

   modport master (
      output wbm_adr_o, wbm_sel_o, wbm_cti_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      input  wbm_dat_i, wbm_ack_i,
      output st_data_o, st_valid_o,
      input  st_ready_i
   );

   modport slave (
      input  wbm_adr_o, wbm_sel_o, wbm_cti_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      output wbm_dat_i, wbm_ack_i,
      input  st_data_o, st_valid_o,
      output st_ready_i
   );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone burst reader: fetches len_words_i words from base_adr_i in bursts of up to
// BURST_LEN beats into a first-word-fall-through FIFO (FIFO_DEPTH >= 2) feeding a stream.
module wb_burst_reader #(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                start_i,
   input  logic [31:0]         base_adr_i,
   input  logic [23:0]         len_words_i,
   output logic                busy_o,
   output logic                done_o,
   wb_burst_reader_if.master   bus
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = AW + 1;
   localparam int CMP_W  = (CNT_W > 6) ? CNT_W : 6;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [5:0]       BLEN_MAX = 6'(BURST_LEN);

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DRAIN} state_e;

   state_e      state_q;
   logic [29:0] wadr_q;
   logic [23:0] rem_q;
   logic [5:0]  beats_q;
   logic        busy_q, done_q, cyc_q, stb_q;
   logic [2:0]  cti_q;

   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [CNT_W-1:0] count, free;
   logic [5:0]       blen;
   logic             push, pop, fifo_empty, space_ok;
   logic             adr_lsb_unused;

   assign adr_lsb_unused = ^base_adr_i[1:0];

   assign count      = wr_ptr_q - rd_ptr_q;
   assign free       = DEPTH_C - count;
   assign fifo_empty = (count == '0);
   assign blen       = (rem_q < 24'(BURST_LEN)) ? rem_q[5:0] : BLEN_MAX;
   // Pushes only happen in BURST, so free space can only grow while waiting here.
   assign space_ok   = (CMP_W'(free) >= CMP_W'(blen));

   assign push = bus.wbm_ack_i & cyc_q & stb_q;
   assign pop  = ~fifo_empty & bus.st_ready_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         cti_q   <= CTI_CLASSIC;
         wadr_q  <= '0;
         rem_q   <= '0;
         beats_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (len_words_i != 24'd0) begin
                     wadr_q  <= base_adr_i[31:2];
                     rem_q   <= len_words_i;
                     busy_q  <= 1'b1;
                     state_q <= WAIT_SPACE;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            WAIT_SPACE: begin
               if (space_ok) begin
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  beats_q <= blen;
                  cti_q   <= (blen == 6'd1) ? CTI_CLASSIC : CTI_INCR;
                  state_q <= BURST;
               end
            end
            BURST: begin
               if (push) begin
                  wadr_q  <= wadr_q + 30'd1;
                  rem_q   <= rem_q - 24'd1;
                  beats_q <= beats_q - 6'd1;
                  if (beats_q == 6'd1) begin
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                     cti_q   <= CTI_CLASSIC;
                     state_q <= (rem_q == 24'd1) ? DRAIN : WAIT_SPACE;
                  end else if (beats_q == 6'd2) begin
                     cti_q <= CTI_END;
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.wbm_dat_i;
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign bus.wbm_adr_o  = {wadr_q, 2'b00};
   assign bus.wbm_sel_o  = 4'hF;
   assign bus.wbm_cti_o  = cti_q;
   assign bus.wbm_we_o   = 1'b0;
   assign bus.wbm_cyc_o  = cyc_q;
   assign bus.wbm_stb_o  = stb_q;
   assign bus.st_data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.st_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomized scoreboard bench for wb_burst_reader: a Wishbone slave returns address-derived
// data, expected words are queued at start and compared as the stream emits them.
module tb_wb_burst_reader;
   localparam int BL = 8;
   localparam int FD = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base = '0;
   logic [23:0] len = '0;
   logic        busy, done;

   wb_burst_reader_if bus();

   wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .start_i    (start),
      .base_adr_i (base),
      .len_words_i(len),
      .busy_o     (busy),
      .done_o     (done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q[$];

   int ack_mode = 0;    // 0: ack every beat, 1: random acks
   int ready_mode = 0;  // 0: ready high, 1: random, 2: held low
   bit spurious = 1'b0; // random acks while no cycle is open

   bit          m_busy = 1'b0;
   logic [31:0] m_adr = '0;
   int          m_rem = 0, m_beat = 0, m_blen = 0, occ = 0;
   int          fetched = 0, done_cnt = 0, burst_cnt = 0;
   bit          cyc_seen = 1'b0, last_final = 1'b0, prev_cyc = 1'b0;

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave and sink drivers, updated just after each rising edge
   always begin
      @(posedge clk);
      #1;
      if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
         bus.wbm_ack_i = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
         bus.wbm_dat_i = slave_data(bus.wbm_adr_o);
      end else begin
         bus.wbm_ack_i = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
         bus.wbm_dat_i = $urandom;
      end
      case (ready_mode)
         0:       bus.st_ready_i = 1'b1;
         1:       bus.st_ready_i = $urandom_range(0, 1) == 1;
         default: bus.st_ready_i = 1'b0;
      endcase
   end

   // Monitor: bus protocol model, stream scoreboard, done tracking
   always @(negedge clk) begin
      if (!rst) begin
         if (last_final) begin
            check("cyc_drop_after_final", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
            last_final = 1'b0;
         end
         if (bus.wbm_cyc_o) cyc_seen = 1'b1;
         if (bus.wbm_cyc_o && !prev_cyc) burst_cnt++;
         prev_cyc = bus.wbm_cyc_o;
         if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
            logic [2:0] exp_cti;
            if (m_beat == 0) m_blen = (m_rem < BL) ? m_rem : BL;
            if (m_blen == 1)               exp_cti = 3'b000;
            else if (m_beat == m_blen - 1) exp_cti = 3'b111;
            else                           exp_cti = 3'b010;
            check("beat_adr", bus.wbm_adr_o, m_adr);
            check("beat_we_sel_cti", {bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_cti_o},
                  {1'b0, 4'hF, exp_cti});
            m_adr = m_adr + 32'd4;
            m_rem--;
            m_beat++;
            fetched++;
            occ++;
            check("fifo_no_overflow", occ <= FD, 1);
            if (m_beat == m_blen) begin
               m_beat = 0;
               last_final = 1'b1;
            end
         end
         if (bus.st_valid_o && bus.st_ready_i) begin
            occ--;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stream_extra_word: got %h expected none", bus.st_data_o);
            end else begin
               check("stream_data", bus.st_data_o, sb_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            if (m_busy) check("done_after_all_words", sb_q.size(), 0);
            m_busy = 1'b0;
         end
      end
   end

   task automatic do_start(input logic [31:0] b, input logic [23:0] l);
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = b;
      len   = l;
      if (!m_busy && l != 0) begin
         m_busy = 1'b1;
         m_adr  = {b[31:2], 2'b00};
         m_rem  = int'(l);
         m_beat = 0;
         for (int i = 0; i < int'(l); i++) sb_q.push_back(slave_data(m_adr + 32'(4 * i)));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = $urandom;
      len   = 24'($urandom);
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0, n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s: done_o not seen within %0d cycles", name, budget);
      end
      #1;
      check({name, "_busy_clear"}, {done, busy}, 0);
      repeat (10) @(posedge clk);
      check({name, "_single_done"}, done_cnt, d0 + 1);
      check({name, "_words_left"}, sb_q.size(), 0);
   endtask

   task automatic model_clear();
      sb_q.delete();
      m_busy = 1'b0; m_beat = 0; m_rem = 0; occ = 0;
      last_final = 1'b0; prev_cyc = 1'b0;
   endtask

   initial begin
      int f0, b0, d0, n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {busy, done, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.st_valid_o}, 0);
      check("rst_cti", bus.wbm_cti_o, 0);
      check("rst_adr", bus.wbm_adr_o, 0);
      rst = 1'b0;

      // Single full burst
      b0 = burst_cnt;
      do_start(32'h0000_0100, 24'd8);
      check("busy_after_start", busy, 1);
      wait_done("len8", 500);
      check("len8_bursts", burst_cnt - b0, 1);

      // Three bursts 8,8,4
      b0 = burst_cnt;
      do_start(32'h0000_0000, 24'd20);
      wait_done("len20", 800);
      check("len20_bursts", burst_cnt - b0, 3);

      // Single beat
      b0 = burst_cnt;
      do_start(32'h0000_0043, 24'd1);
      wait_done("len1", 200);
      check("len1_bursts", burst_cnt - b0, 1);

      // Zero length
      cyc_seen = 1'b0;
      d0 = done_cnt;
      do_start(32'h0000_0500, 24'd0);
      check("len0_done_next", {done, busy}, 2'b10);
      repeat (10) @(posedge clk);
      check("len0_no_cycle", cyc_seen, 0);
      check("len0_single_done", done_cnt, d0 + 1);

      // Address wrap
      do_start(32'hFFFF_FFF8, 24'd4);
      wait_done("wrap", 200);

      // Sink stalled: only FIFO_DEPTH words may be fetched
      f0 = fetched;
      ready_mode = 2;
      do_start(32'h0001_0000, 24'd40);
      repeat (300) @(posedge clk);
      #1;
      check("stall_fetched", fetched - f0, FD);
      check("stall_cyc_idle", bus.wbm_cyc_o, 0);
      check("stall_valid", bus.st_valid_o, 1);
      ready_mode = 1;
      wait_done("stall_release", 3000);

      // Reset during the third beat
      ready_mode = 0;
      d0 = done_cnt;
      f0 = fetched;
      do_start(32'h0000_0200, 24'd8);
      n = 0;
      while (fetched - f0 < 2 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rst_mid_reached_beat3", fetched - f0, 2);
      rst = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      check("rst_mid_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
      check("rst_mid_valid_busy", {bus.st_valid_o, busy, done}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      check("rst_mid_no_done", done_cnt, d0);
      do_start(32'h0000_0300, 24'd12);
      wait_done("after_reset", 500);

      // Randomized transfers with stalls, slow acks and stray acks
      spurious = 1'b1;
      for (int t = 0; t < 10; t++) begin
         logic [23:0] l;
         ack_mode   = $urandom_range(0, 1);
         ready_mode = $urandom_range(0, 1);
         l = 24'($urandom_range(1, 50));
         do_start($urandom, l);
         if (l >= 4 && $urandom_range(0, 1) == 1) do_start($urandom, 24'($urandom_range(1, 9)));
         wait_done("random", 3000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_burst_reader.md
WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8: maximum beats per Wishbone burst, legal range 1..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: read-data FIFO entries; power of 2 and >= BURST_LEN.
REQ-003 SHALL have port wb_clk_i, input, 1: single clock for all logic.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start_i, input, 1: one-cycle request to start a transfer.
REQ-006 SHALL have port base_adr_i, input, 32: start byte address, bits [1:0] ignored, sampled on accepted start_i.
REQ-007 SHALL have port len_words_i, input, 24: transfer length in 32-bit words, sampled on accepted start_i.
REQ-008 SHALL have port busy_o, output, 1: transfer in progress.
REQ-009 SHALL have port done_o, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports wbm_adr_o (out 32), wbm_sel_o (out 4), wbm_cti_o (out 3), wbm_we_o (out 1), wbm_cyc_o (out 1), wbm_stb_o (out 1): Wishbone master request.
REQ-011 SHALL have ports wbm_dat_i (in 32) and wbm_ack_i (in 1): Wishbone master response.
REQ-012 SHALL have ports st_data_o (out 32), st_valid_o (out 1), st_ready_i (in 1): output word stream.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_SPACE, BURST, DRAIN.
REQ-014 IDLE: start_i with len_words_i != 0 SHALL latch address/length, set busy_o next cycle, go to WAIT_SPACE.
REQ-015 IDLE: start_i with len_words_i == 0 SHALL pulse done_o the next cycle, no bus cycle, busy_o stays 0.
REQ-016 start_i while busy_o = 1 SHALL be ignored.
REQ-017 Burst size SHALL be blen = min(BURST_LEN, remaining words).
REQ-018 WAIT_SPACE: when FIFO free entries >= blen, SHALL go to BURST with wbm_cyc_o = wbm_stb_o = 1 from the next cycle.
REQ-019 BURST: wbm_we_o = 0, wbm_sel_o = 4'hF; wbm_adr_o = current word address x4, +4 per ack.
REQ-020 wbm_cti_o SHALL be 3'b010 on non-final beats, 3'b111 on the final beat, 3'b000 when blen = 1.
REQ-021 Each cycle with wbm_ack_i = 1 and wbm_stb_o = 1 SHALL write wbm_dat_i into the FIFO and decrement remaining.
REQ-022 After the final-beat ack, cyc/stb SHALL drop the next cycle; next state WAIT_SPACE if remaining > 0, else DRAIN.
REQ-023 wbm_ack_i while wbm_cyc_o = 0 SHALL be ignored (no FIFO write).
REQ-024 Address SHALL wrap modulo 2^32 without error.
REQ-025 FIFO SHALL be first-word-fall-through: st_valid_o = !empty, st_data_o = head; pop when st_valid_o & st_ready_i.
REQ-026 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; free-space check SHALL ensure the FIFO never overflows.
REQ-027 DRAIN: when FIFO empty, SHALL pulse done_o one cycle, clear busy_o the same cycle, return to IDLE.
REQ-028 st_ready_i low for any duration SHALL only stall; no word lost or duplicated.

Reset
REQ-029 wb_rst_i SHALL force IDLE, empty the FIFO, clear remaining count.
REQ-030 During and after reset: busy_o, done_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, st_valid_o = 0; wbm_cti_o = 0; wbm_adr_o = 0.
REQ-031 Reset mid-burst SHALL drop cyc/stb the cycle after reset is sampled; no done_o pulse.

Verification
REQ-032 base 0x100, len 8, ready=1, slave acks every cycle -> one burst adr 0x100..0x11C, cti 010x7 then 111, 8 words out in order, done_o once.
REQ-033 base 0x0, len 20 -> bursts of 8,8,4; third burst final cti 111; 20 words out; done_o after last pop.
REQ-034 len 1 -> single beat with cti 000; len 0 -> done_o next cycle, cyc never asserted.
REQ-035 st_ready_i held 0 after start, len 40 -> at most FIFO_DEPTH words fetched, cyc idle; release -> all 40 words, no loss.
REQ-036 base 0xFFFFFFF8, len 4 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-037 Reset asserted during 3rd beat -> cyc/stb low next cycle, st_valid_o 0, no done_o; new start then completes normally.
